// File: rtl/ram_burst_reader_pkg.sv
// ---------------------------------------------------------------------------
// ram_reader_pkg
//   Shared types for the RAM burst reader.
//   rd_state_e : burst FSM state (IDLE waits for a command, RUN streams it).
// ---------------------------------------------------------------------------
package ram_reader_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rd_state_e;

endpackage

// File: rtl/ram_burst_reader_if.sv
// ---------------------------------------------------------------------------
// ram_burst_reader_if
//   Valid/ready word stream with a last flag.
//   valid : word present        (producer -> consumer)
//   ready : consumer accepts    (consumer -> producer)
//   data  : word payload        (producer -> consumer)
//   last  : final word of burst (producer -> consumer), qualified by valid
//   master modport = producer side, slave modport = consumer side.
// ---------------------------------------------------------------------------
interface ram_burst_reader_if #(
  parameter int WORD_WIDTH = 32
) ();

  logic                  valid;
  logic                  ready;
  logic [WORD_WIDTH-1:0] data;
  logic                  last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/ram_burst_reader_fifo.sv
// ---------------------------------------------------------------------------
// ram_rd_fifo
//   Synchronous FIFO of {last, data} words feeding the output stream.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   push_i        : write push_data_i/push_last_i this cycle
//   push_data_i   : word to store
//   push_last_i   : last-of-burst tag for the word
//   m_if          : output stream (head of FIFO), pops on valid && ready
//   count_o       : current number of stored entries (0..FIFO_DEPTH)
//   The writer guarantees it never pushes into a full FIFO (credit scheme in
//   the parent), so push does not look at fullness.
// ---------------------------------------------------------------------------
module ram_rd_fifo #(
  parameter  int WORD_WIDTH = 32,
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  push_i,
  input  logic [WORD_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  ram_burst_reader_if.master    m_if,
  output logic [CNT_W-1:0]      count_o
);

  logic [WORD_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic                  last_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  pop;

  assign pop     = m_if.valid && m_if.ready;
  assign count_o = count_q;

  // Head word is forced to zero while empty so the stream reads 0 out of reset.
  assign m_if.valid = (count_q != '0);
  assign m_if.data  = m_if.valid ? data_mem[rd_ptr_q] : '0;
  assign m_if.last  = m_if.valid && last_mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      data_mem[wr_ptr_q] <= push_data_i;
      last_mem[wr_ptr_q] <= push_last_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push_i, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(push_i && !pop && (count_q == CNT_W'(FIFO_DEPTH))));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(pop && (count_q == '0)));

endmodule

// File: rtl/ram_burst_reader.sv
// ---------------------------------------------------------------------------
// ram_burst_reader
//   Read master for a 1-cycle-latency RAM port without read enable. Accepts a
//   burst command (start address, length-1), walks the RAM addresses with
//   wrap-around and returns the words as a valid/ready stream with last flag.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o / cmd_addr_i / cmd_len_i : burst command
//   ram_addr_o    : registered RAM read address
//   ram_data_i    : RAM read data for the previous cycle's address
//   m_valid_o / m_ready_i / m_data_o / m_last_o : output word stream
//   busy_o        : burst in progress
// ---------------------------------------------------------------------------
module ram_burst_reader
  import ram_reader_pkg::*;
#(
  parameter  int BYTE_WIDTH    = 8,
  parameter  int BYTES_IN_WORD = 4,
  parameter  int WORD_COUNT    = 256,
  parameter  int FIFO_DEPTH    = 4,
  localparam int ADDR_WIDTH    = $clog2(WORD_COUNT),
  localparam int WORD_WIDTH    = BYTE_WIDTH * BYTES_IN_WORD
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_len_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [WORD_WIDTH-1:0] ram_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [WORD_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  rd_state_e             state_q;
  logic                  cmd_ready_q;
  logic                  busy_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [ADDR_WIDTH-1:0] next_addr_q;
  logic [ADDR_WIDTH:0]   left_q;        // words still to be issued
  logic                  pres_vld_q;    // an address is on ram_addr_o this cycle
  logic                  pres_last_q;
  logic                  data_vld_q;    // ram_data_i carries a requested word
  logic                  data_last_q;

  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        credit_used_d;
  logic                  cmd_hs_d;
  logic                  issue_d;
  logic                  last_hs_d;

  ram_burst_reader_if #(.WORD_WIDTH(WORD_WIDTH)) m_stream ();

  ram_rd_fifo #(
    .WORD_WIDTH (WORD_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (data_vld_q),
    .push_data_i (ram_data_i),
    .push_last_i (data_last_q),
    .m_if        (m_stream),
    .count_o     (fifo_count)
  );

  assign m_stream.ready = m_ready_i;
  assign m_valid_o      = m_stream.valid;
  assign m_data_o       = m_stream.data;
  assign m_last_o       = m_stream.last;
  assign cmd_ready_o    = cmd_ready_q;
  assign busy_o         = busy_q;
  assign ram_addr_o     = ram_addr_q;

  // Every issued read owns a FIFO slot from issue until it is popped, so the
  // FIFO can never be pushed while full.
  assign credit_used_d = {1'b0, fifo_count}
                       + (CNT_W + 1)'(pres_vld_q)
                       + (CNT_W + 1)'(data_vld_q);

  assign cmd_hs_d  = cmd_valid_i && cmd_ready_q;
  assign issue_d   = (state_q == RUN) && (left_q != '0)
                  && (credit_used_d < (CNT_W + 1)'(FIFO_DEPTH));
  assign last_hs_d = m_valid_o && m_ready_i && m_last_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      ram_addr_q  <= '0;
      next_addr_q <= '0;
      left_q      <= '0;
      pres_vld_q  <= 1'b0;
      pres_last_q <= 1'b0;
      data_vld_q  <= 1'b0;
      data_last_q <= 1'b0;
    end else begin
      data_vld_q  <= pres_vld_q;
      data_last_q <= pres_last_q;
      pres_vld_q  <= 1'b0;
      pres_last_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // The first word is issued on the handshake edge itself; the FIFO
          // is empty in IDLE so a credit is always available.
          if (cmd_hs_d) begin
            ram_addr_q  <= cmd_addr_i;
            next_addr_q <= cmd_addr_i + ADDR_WIDTH'(1);
            left_q      <= {1'b0, cmd_len_i};
            pres_vld_q  <= 1'b1;
            pres_last_q <= (cmd_len_i == '0);
            state_q     <= RUN;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        RUN: begin
          if (issue_d) begin
            ram_addr_q  <= next_addr_q;
            next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
            left_q      <= left_q - (ADDR_WIDTH + 1)'(1);
            pres_vld_q  <= 1'b1;
            pres_last_q <= (left_q == (ADDR_WIDTH + 1)'(1));
          end
          if (last_hs_d) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  a_inputs_known: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !$isunknown({cmd_valid_i, m_ready_i}));

  a_cmd_known: assert property (@(posedge clk_i) disable iff (!rstn_i)
    cmd_valid_i |-> !$isunknown({cmd_addr_i, cmd_len_i}));

  a_stall_stable: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (m_valid_o && !m_ready_i) |=> (m_valid_o && $stable(m_data_o) && $stable(m_last_o)));

  a_done_clean: assert property (@(posedge clk_i) disable iff (!rstn_i)
    last_hs_d |=> (fifo_count == '0) && !pres_vld_q && !data_vld_q);

endmodule

// File: tb/tb_ram_burst_reader.sv
module tb_ram_burst_reader;

  localparam int AW = 8;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic [AW-1:0] ram_addr;
  logic [WW-1:0] ram_data;
  logic          busy;

  ram_burst_reader_if #(.WORD_WIDTH(WW)) mif ();

  always #5 clk = ~clk;

  ram_burst_reader dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .ram_addr_o  (ram_addr),
    .ram_data_i  (ram_data),
    .m_valid_o   (mif.valid),
    .m_ready_i   (mif.ready),
    .m_data_o    (mif.data),
    .m_last_o    (mif.last),
    .busy_o      (busy)
  );

  // RAM model: word = address, one cycle read latency.
  logic [WW-1:0] ram_mem [256];
  initial for (int i = 0; i < 256; i++) ram_mem[i] = WW'(i);
  always @(posedge clk) ram_data <= ram_mem[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic          last;
    logic [WW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = random 50%, 2 = stalled.
  int ready_mode = 0;
  initial begin
    mif.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       mif.ready = 1'b1;
        1:       mif.ready = 1'($urandom_range(0, 1));
        default: mif.ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard.
  int            pops_total    = 0;
  int            pop_cyc [0:1023];
  int            last_rise_cyc = 0;
  logic          prev_valid    = 1'b0;
  logic          pend_rdy      = 1'b0;
  logic          hold_v        = 1'b0;
  logic [WW-1:0] hold_data     = '0;
  logic          hold_last     = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      pend_rdy   = 1'b0;
      hold_v     = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (pend_rdy) begin
        chk("cmd_ready_after_last", 32'(cmd_ready), 32'd1);
        chk("busy_after_last", 32'(busy), 32'd0);
        pend_rdy = 1'b0;
      end
      if (hold_v) begin
        chk("stall_valid", 32'(mif.valid), 32'd1);
        chk("stall_data", mif.data, hold_data);
        chk("stall_last", 32'(mif.last), 32'(hold_last));
      end
      if (mif.valid && !prev_valid) last_rise_cyc = cyc;
      prev_valid = mif.valid;
      if (mif.valid && mif.ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", mif.data, 32'hDEAD_BEEF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("word data=0x%08h last=%0d", mif.data, mif.last);
          chk("word_data", mif.data, e.data);
          chk("word_last", 32'(mif.last), 32'(e.last));
          if (e.last) pend_rdy = 1'b1;
        end
        if (pops_total < 1024) pop_cyc[pops_total] = cyc;
        pops_total++;
      end
      hold_v    = mif.valid && !mif.ready;
      hold_data = mif.data;
      hold_last = mif.last;
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] l, output int hs);
    logic [AW-1:0] wa;
    exp_t e;
    for (int i = 0; i <= int'(l); i++) begin
      wa     = a + AW'(i);
      e.last = (i == int'(l));
      e.data = WW'(wa);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    hs = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        hs = cyc + 1;
        break;
      end
    end
    if (hs < 0) chk("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int p0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;

    // Reset state.
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_valid", 32'(mif.valid), 32'd0);
    chk("rst_m_last", 32'(mif.last), 32'd0);
    chk("rst_m_data", mif.data, 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic burst, latency and back-to-back words.
    p0 = pops_total;
    send(8'h10, 8'd3, hs);
    drain(50);
    chk("t1_first_valid_latency", 32'(last_rise_cyc - hs), 32'd2);
    chk("t1_consecutive", 32'(pop_cyc[p0 + 3] - pop_cyc[p0]), 32'd3);

    // 2: wrap through address 0.
    send(8'hFE, 8'd3, hs);
    drain(50);

    // 3: random backpressure.
    ready_mode = 1;
    send(8'h20, 8'd15, hs);
    drain(300);
    ready_mode = 0;
    @(posedge clk);

    // 4: single-word burst (ready-after-last checked by the monitor).
    send(8'h33, 8'd0, hs);
    drain(50);

    // 5: long stall, issue limited by credits.
    ready_mode = 2;
    @(posedge clk);
    send(8'h60, 8'd7, hs);
    repeat (20) @(negedge clk);
    chk("t5_issue_stopped", 32'(ram_addr), 32'h63);
    chk("t5_head_data", mif.data, 32'h60);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_cmd_ready_low", 32'(cmd_ready), 32'd0);
    ready_mode = 0;
    drain(100);

    // Whole RAM in one burst, starting off zero.
    p0 = pops_total;
    send(8'h05, 8'hFF, hs);
    drain(600);
    chk("full_ram_consecutive", 32'(pop_cyc[p0 + 255] - pop_cyc[p0]), 32'd255);

    // 6: reset mid-burst.
    send(8'h40, 8'd7, hs);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (exp_q.size() <= 5) break;
    end
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_rst_m_valid", 32'(mif.valid), 32'd0);
    chk("t6_rst_m_last", 32'(mif.last), 32'd0);
    chk("t6_rst_m_data", mif.data, 32'd0);
    chk("t6_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ram_addr", 32'(ram_addr), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h80, 8'd2, hs);
    drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
